seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//   Time-multiplexed digit-select controller for N-digit common-anode/cathode 7-segment displays.
//   Generates a paced digit index and a one-hot digit-select bus, with forward, reverse,
//   ping-pong and hold scan modes plus per-digit blanking.
//   Sits between the display data mux (consumes dig_idx/tick) and the select pins.
// PARAMETERS
//   DIGITS      4       number of digits scanned, legal range 2..8
//   CNT_MAX     50000   clocks per digit dwell (1 ms at 50 MHz), legal >= 1
//   SEL_ACT_LOW 1       1: selected digit driven 0, others 1; 0: inverted polarity
// PORTS
//   clk         in   1                  system clock, all logic on rising edge
//   rst_n       in   1                  asynchronous active-low reset
//   en          in   1                  1: scanning runs; 0: pause and blank all digits
//   mode        in   2                  00 fwd, 01 rev, 10 ping-pong, 11 hold
//   blank_mask  in   DIGITS             bit i = 1 forces digit i inactive while selected
//   seg_sel     out  DIGITS             registered digit-select bus, polarity per SEL_ACT_LOW
//   dig_idx     out  $clog2(DIGITS)     registered index of the currently selected digit
//   tick        out  1                  registered 1-cycle pulse on the edge dig_idx advances
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - cnt=0, dig_idx=0, dir=up, tick=0.
//     - seg_sel = all inactive (all 1s if SEL_ACT_LOW=1).
//   Prescaler:
//     - cnt counts 0..CNT_MAX-1 while en=1; holds its value while en=0.
//     - On an edge with en=1 and cnt==CNT_MAX-1: cnt<=0, tick<=1, dig_idx<=next.
//       tick=0 on all other edges.
//     - CNT_MAX=1: tick high every cycle while en=1.
//   Next index (mode sampled only on the tick edge):
//     - fwd: idx+1, wraps DIGITS-1 -> 0; dir<=up.
//     - rev: idx-1, wraps 0 -> DIGITS-1; dir<=down.
//     - ping-pong: sequence 0,1,..,N-1,N-2,..,1,0,1..; endpoints not repeated.
//         dir=up at N-1 -> dir<=down, idx<=N-2.
//         dir=down at 0 -> dir<=up, idx<=1.
//         Otherwise step in dir.
//     - hold: dig_idx unchanged; cnt and tick continue.
//     - A mode change between ticks has no effect until the next tick. Entering
//       ping-pong uses the current dir (fwd left it up, rev left it down).
//   seg_sel:
//     - Registered each cycle from the next-state dig_idx, so it always aligns with dig_idx.
//     - Active only at bit dig_idx.
//     - Forced all-inactive when en=0 or blank_mask[dig_idx]=1.
//     - blank_mask and en changes appear on seg_sel after exactly 1 clock.
//   Pause/resume:
//     - en 1->0: dig_idx, cnt and dir frozen; seg_sel inactive from the next edge.
//     - en 0->1: selection restored on the next edge; scanning resumes from the frozen cnt.
//   Reset mid-scan: outputs return to reset values immediately (async). Scan restarts at
//     digit 0, dir=up, with a full CNT_MAX dwell.
//   No combinational path from any input to any output.
// TESTING
//   T1 DIGITS=4, CNT_MAX=3, SEL_ACT_LOW=1, mode=00, en=1 after reset:
//      -> dig_idx 0,1,2,3,0 changing every 3 clocks.
//      -> seg_sel 1110,1101,1011,0111,1110; tick 1 cycle wide every 3 clocks.
//   T2 Same config, mode=10:
//      -> dig_idx 0,1,2,3,2,1,0,1; seg_sel 1110,1101,1011,0111,1011,1101,1110,1101.
//   T3 mode=01 from idx 0 -> 3,2,1,0,3.
//      Switch to 10 mid-dwell at idx 2 (dir=down) -> next ticks 1,0,1,2.
//   T4 blank_mask=0100 at idx 2 -> seg_sel 1111 for that dwell (1 clk latency), dig_idx still 2.
//      en=0 for 10 clks -> seg_sel 1111, dig_idx and cnt frozen, tick=0.
//      en=1 -> resumes the remaining dwell.
//   T5 rst_n pulsed low mid-dwell at idx 3, mode=10 dir=down:
//      -> seg_sel=1111, dig_idx=0, tick=0 asynchronously.
//      -> after release: first tick exactly CNT_MAX clocks later, idx 1.
//   T6 DIGITS=8, CNT_MAX=1, SEL_ACT_LOW=0:
//      -> tick every cycle; seg_sel 00000001..10000000 walks one bit per clock, then wraps.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Digit-select scanner for multiplexed N-digit 7-segment displays (fwd/rev/ping-pong/hold).
// Latency: seg_sel, dig_idx and tick are all registered; en/blank_mask reach seg_sel after 1 clock.
// Backpressure: none; free-running pacer, en=0 pauses scanning and blanks the display.
//
// Ports:
//   clk        rising-edge system clock
//   rst_n      asynchronous active-low reset
//   en         1 = scan, 0 = pause (index/prescaler/direction frozen, all digits inactive)
//   mode       00 fwd, 01 rev, 10 ping-pong, 11 hold (acted on only at a tick)
//   blank_mask per-digit force-inactive
//   seg_sel    one-hot digit select, polarity set by SEL_ACT_LOW
//   dig_idx    index of the digit currently selected
//   tick       1-cycle pulse on the edge where dig_idx advances
module seg_scan_ctrl #(
    parameter int DIGITS      = 4,
    parameter int CNT_MAX     = 50000,
    parameter bit SEL_ACT_LOW = 1'b1,
    localparam int IW         = $clog2(DIGITS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [DIGITS-1:0] blank_mask,
    output logic [DIGITS-1:0] seg_sel,
    output logic [IW-1:0]     dig_idx,
    output logic              tick
);

    localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
    localparam logic [CW-1:0]     CNT_LAST = CW'(CNT_MAX - 1);
    localparam logic [DIGITS-1:0] SEL_IDLE = {DIGITS{SEL_ACT_LOW}};
    localparam logic [DIGITS-1:0] ONE_HOT0 = DIGITS'(1);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    typedef enum logic [1:0] {
        MODE_FWD  = 2'b00,
        MODE_REV  = 2'b01,
        MODE_PING = 2'b10,
        MODE_HOLD = 2'b11
    } mode_t;

    dir_t              dir, dir_nxt, step_dir;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [IW-1:0]     idx_nxt, step_idx;
    logic              tick_nxt;
    logic [DIGITS-1:0] onehot, sel_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            dig_idx <= '0;
            dir     <= DIR_UP;
            tick    <= 1'b0;
            seg_sel <= SEL_IDLE;
        end else begin
            cnt     <= cnt_nxt;
            dig_idx <= idx_nxt;
            dir     <= dir_nxt;
            tick    <= tick_nxt;
            seg_sel <= sel_nxt;
        end
    end

    always_comb begin
        step_idx = dig_idx;
        step_dir = dir;
        cnt_nxt  = cnt;
        idx_nxt  = dig_idx;
        dir_nxt  = dir;
        tick_nxt = 1'b0;

        // Candidate index/direction for the next tick; only committed when the
        // prescaler expires, so mode changes between ticks are invisible.
        case (mode_t'(mode))
            MODE_FWD: begin
                step_idx = (dig_idx == IDX_LAST) ? '0 : dig_idx + IW'(1);
                step_dir = DIR_UP;
            end
            MODE_REV: begin
                step_idx = (dig_idx == '0) ? IDX_LAST : dig_idx - IW'(1);
                step_dir = DIR_DOWN;
            end
            MODE_PING: begin
                // Bounce at the ends without dwelling twice on an endpoint.
                if (dir == DIR_UP) begin
                    if (dig_idx == IDX_LAST) begin
                        step_idx = IDX_LAST - IW'(1);
                        step_dir = DIR_DOWN;
                    end else begin
                        step_idx = dig_idx + IW'(1);
                    end
                end else begin
                    if (dig_idx == '0) begin
                        step_idx = IW'(1);
                        step_dir = DIR_UP;
                    end else begin
                        step_idx = dig_idx - IW'(1);
                    end
                end
            end
            default: begin
                step_idx = dig_idx;
                step_dir = dir;
            end
        endcase

        if (en) begin
            if (cnt == CNT_LAST) begin
                cnt_nxt  = '0;
                tick_nxt = 1'b1;
                idx_nxt  = step_idx;
                dir_nxt  = step_dir;
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end

        // Select is built from the next-state index so seg_sel and dig_idx
        // always change on the same edge.
        onehot = ONE_HOT0 << idx_nxt;
        if (!en || blank_mask[idx_nxt]) begin
            sel_nxt = SEL_IDLE;
        end else begin
            sel_nxt = SEL_ACT_LOW ? ~onehot : onehot;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

    logic       clk;
    logic       rst_n, rst_nb;
    logic       en, en_b;
    logic [1:0] mode, mode_b;
    logic [3:0] blank_mask;
    logic [7:0] blank_b;
    logic [3:0] seg_sel;
    logic [1:0] dig_idx;
    logic       tick;
    logic [7:0] seg_sel_b;
    logic [2:0] dig_idx_b;
    logic       tick_b;

    int n_run  = 0;
    int n_fail = 0;

    seg_scan_ctrl #(.DIGITS(4), .CNT_MAX(3), .SEL_ACT_LOW(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mode       (mode),
        .blank_mask (blank_mask),
        .seg_sel    (seg_sel),
        .dig_idx    (dig_idx),
        .tick       (tick)
    );

    seg_scan_ctrl #(.DIGITS(8), .CNT_MAX(1), .SEL_ACT_LOW(1'b0)) dut_b (
        .clk        (clk),
        .rst_n      (rst_nb),
        .en         (en_b),
        .mode       (mode_b),
        .blank_mask (blank_b),
        .seg_sel    (seg_sel_b),
        .dig_idx    (dig_idx_b),
        .tick       (tick_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic [3:0] blank;
        logic [1:0] idx;
        logic [3:0] sel;
    } row_t;

    row_t rows[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string name, input logic [1:0] ei, input logic [3:0] es, input logic et);
        chk({name, ".idx"},  32'(dig_idx), 32'(ei));
        chk({name, ".sel"},  32'(seg_sel), 32'(es));
        chk({name, ".tick"}, 32'(tick),    32'(et));
    endtask

    function automatic row_t mk(input logic [1:0] m, input logic [3:0] b,
                                input logic [1:0] i, input logic [3:0] s);
        row_t r;
        r.en = 1'b1; r.mode = m; r.blank = b; r.idx = i; r.sel = s;
        return r;
    endfunction

    initial begin
        // forward
        rows.push_back(mk(2'b00, 4'b0000, 2'd1, 4'b1101));
        rows.push_back(mk(2'b00, 4'b0000, 2'd2, 4'b1011));
        rows.push_back(mk(2'b00, 4'b0000, 2'd3, 4'b0111));
        rows.push_back(mk(2'b00, 4'b0000, 2'd0, 4'b1110));
        // ping-pong from 0, dir up
        rows.push_back(mk(2'b10, 4'b0000, 2'd1, 4'b1101));
        rows.push_back(mk(2'b10, 4'b0000, 2'd2, 4'b1011));
        rows.push_back(mk(2'b10, 4'b0000, 2'd3, 4'b0111));
        rows.push_back(mk(2'b10, 4'b0000, 2'd2, 4'b1011));
        rows.push_back(mk(2'b10, 4'b0000, 2'd1, 4'b1101));
        rows.push_back(mk(2'b10, 4'b0000, 2'd0, 4'b1110));
        rows.push_back(mk(2'b10, 4'b0000, 2'd1, 4'b1101));
        // reverse, wraps 0 -> 3
        rows.push_back(mk(2'b01, 4'b0000, 2'd0, 4'b1110));
        rows.push_back(mk(2'b01, 4'b0000, 2'd3, 4'b0111));
        rows.push_back(mk(2'b01, 4'b0000, 2'd2, 4'b1011));
        rows.push_back(mk(2'b01, 4'b0000, 2'd1, 4'b1101));
        rows.push_back(mk(2'b01, 4'b0000, 2'd0, 4'b1110));
        rows.push_back(mk(2'b01, 4'b0000, 2'd3, 4'b0111));
        rows.push_back(mk(2'b01, 4'b0000, 2'd2, 4'b1011));
        // ping-pong entered with dir down at 2
        rows.push_back(mk(2'b10, 4'b0000, 2'd1, 4'b1101));
        rows.push_back(mk(2'b10, 4'b0000, 2'd0, 4'b1110));
        rows.push_back(mk(2'b10, 4'b0000, 2'd1, 4'b1101));
        rows.push_back(mk(2'b10, 4'b0000, 2'd2, 4'b1011));
        // hold: index stays, tick keeps pulsing
        rows.push_back(mk(2'b11, 4'b0000, 2'd2, 4'b1011));
        rows.push_back(mk(2'b11, 4'b0000, 2'd2, 4'b1011));
        // blanking of digit 2 only
        rows.push_back(mk(2'b11, 4'b0100, 2'd2, 4'b1111));
        rows.push_back(mk(2'b00, 4'b0100, 2'd3, 4'b0111));

        rst_n = 1'b0; en = 1'b0; mode = 2'b00; blank_mask = 4'b0000;
        rst_nb = 1'b0; en_b = 1'b0; mode_b = 2'b00; blank_b = 8'h00;
        #12;
        chk_a("reset", 2'd0, 4'b1111, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        step(); chk_a("first0", 2'd0, 4'b1110, 1'b0);
        step(); chk_a("first1", 2'd0, 4'b1110, 1'b0);

        foreach (rows[r]) begin
            en = rows[r].en; mode = rows[r].mode; blank_mask = rows[r].blank;
            for (int k = 0; k < 3; k++) begin
                step();
                chk_a($sformatf("row%0d.c%0d", r, k), rows[r].idx, rows[r].sel, (k == 0));
            end
        end

        // Pause mid-dwell: everything frozen, then finish the remaining dwell.
        blank_mask = 4'b0000; mode = 2'b00;
        step(); chk_a("pre_pause0", 2'd0, 4'b1110, 1'b1);
        step(); chk_a("pre_pause1", 2'd0, 4'b1110, 1'b0);
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(); chk_a($sformatf("pause%0d", k), 2'd0, 4'b1111, 1'b0);
        end
        en = 1'b1;
        step(); chk_a("resume0", 2'd0, 4'b1110, 1'b0);
        step(); chk_a("resume1", 2'd1, 4'b1101, 1'b1);

        // Blank applied mid-dwell appears exactly one edge later.
        blank_mask = 4'b0010;
        #1; chk("blank_no_comb", 32'(seg_sel), 32'(4'b1101));
        step(); chk_a("blank_on", 2'd1, 4'b1111, 1'b0);
        blank_mask = 4'b0000;
        step(); chk_a("blank_off", 2'd1, 4'b1101, 1'b0);

        // Reach idx 3 with dir down, switch to ping-pong, reset mid-dwell.
        mode = 2'b01;
        step(); chk_a("rv0", 2'd0, 4'b1110, 1'b1);
        step(); step();
        step(); chk_a("rv3", 2'd3, 4'b0111, 1'b1);
        mode = 2'b10;
        step(); chk_a("pp_mid", 2'd3, 4'b0111, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_a("async_rst", 2'd0, 4'b1111, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(); chk_a("rst_d0", 2'd0, 4'b1110, 1'b0);
        step(); chk_a("rst_d1", 2'd0, 4'b1110, 1'b0);
        step(); chk_a("rst_d2", 2'd1, 4'b1101, 1'b1);
        step(); step();
        step(); chk_a("rst_d5", 2'd2, 4'b1011, 1'b1);

        // 8 digits, CNT_MAX=1, active-high selects.
        chk("b.reset.sel", 32'(seg_sel_b), 32'h00);
        chk("b.reset.tick", 32'(tick_b), 32'h0);
        @(negedge clk);
        rst_nb = 1'b1;
        en_b   = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk($sformatf("b.idx%0d", k),  32'(dig_idx_b), 32'(k % 8));
            chk($sformatf("b.sel%0d", k),  32'(seg_sel_b), 32'h1 << (k % 8));
            chk($sformatf("b.tick%0d", k), 32'(tick_b),    32'h1);
        end
        en_b = 1'b0;
        step();
        chk("b.pause.idx",  32'(dig_idx_b), 32'(4));
        chk("b.pause.sel",  32'(seg_sel_b), 32'h00);
        chk("b.pause.tick", 32'(tick_b),    32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
